// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit owning the HI/LO register pair.
// Shift-add multiply and restoring divide share one 2*XLEN accumulator.
module muldiv_hilo #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            op,
    input  logic            ifunsigned,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo,
    output logic [1:0]      dbg_state
);

    localparam int CW = $clog2(XLEN) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Handshake: start is accepted on any edge where busy is low (IDLE or
    // DONE); while busy is high start, mthi and mtlo are dropped, and done
    // pulses for exactly one cycle once HI/LO hold the new result.

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic              op_q, op_d;
    logic              neg_q, neg_d;
    logic              rneg_q, rneg_d;
    logic              dbz_q, dbz_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_trial;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] mul_res;
    logic              can_accept;

    always_comb begin
        a_neg = !ifunsigned && A[XLEN-1];
        b_neg = !ifunsigned && B[XLEN-1];
        abs_a = a_neg ? (~A + 1'b1) : A;
        abs_b = b_neg ? (~B + 1'b1) : B;
    end

    // One multiply step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    end

    // One restoring divide step; the difference always fits XLEN bits when
    // the trial value is not below the divisor, so modular subtraction is exact.
    always_comb begin
        div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_trial >= {1'b0, opb_q});
        div_rem   = div_trial[XLEN-1:0] - opb_q;
    end

    always_comb begin
        mul_res = neg_q ? (~acc_q + 1'b1) : acc_q;
    end

    always_comb begin
        can_accept = (state_q == S_IDLE) || (state_q == S_DONE);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        op_d    = op_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dbz_d   = dbz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                dbz_d   = 1'b0;
                if (start) begin
                    op_d   = op;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    acc_d  = {{XLEN{1'b0}}, abs_a};
                    opb_d  = abs_b;
                    cnt_d  = CW'(XLEN);
                    if (op && (B == '0)) begin
                        state_d = S_DONE;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (op_q) begin
                    acc_d = {div_ge ? div_rem : div_trial[XLEN-1:0],
                             acc_q[XLEN-2:0], div_ge};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                if (op_q) begin
                    lo_d = neg_q  ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
                    hi_d = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1)
                                  : acc_q[2*XLEN-1:XLEN];
                end else begin
                    hi_d = mul_res[2*XLEN-1:XLEN];
                    lo_d = mul_res[XLEN-1:0];
                end
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Software writes only land while idle; the FIX write above can
        // never collide with them.
        if (can_accept) begin
            if (mthi) begin
                hi_d = wdata;
            end
            if (mtlo) begin
                lo_d = wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            op_q    <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dbz_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dbz_q   <= dbz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        busy        = (state_q == S_RUN) || (state_q == S_FIX);
        done        = (state_q == S_DONE);
        div_by_zero = (state_q == S_DONE) && dbz_q;
        hi          = hi_q;
        lo          = lo_q;
        dbg_state   = state_q;
    end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Directed and randomized bench for muldiv_hilo, checked against a
// plain-arithmetic HI/LO model.
module tb_muldiv_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        ifunsigned = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_hilo #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .ifunsigned(ifunsigned), .A(A), .B(B), .mthi(mthi), .mtlo(mtlo),
        .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: full-width integer arithmetic on sign- or zero-extended operands.
    task automatic model_op(input logic o, input logic u, input logic [31:0] a,
                            input logic [31:0] b, output logic dbz);
        longint sa, sb;
        logic [63:0] p;
        dbz = 1'b0;
        sa = u ? {32'b0, a} : {{32{a[31]}}, a};
        sb = u ? {32'b0, b} : {{32{b[31]}}, b};
        if (!o) begin
            p = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
        end else if (b == 32'd0) begin
            dbz = 1'b1;
        end else begin
            m_lo = 32'(sa / sb);
            m_hi = 32'(sa % sb);
        end
    endtask

    task automatic launch(input logic o, input logic u, input logic [31:0] a, input logic [31:0] b);
        op = o;
        ifunsigned = u;
        A = a;
        B = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle 1; returns at the negedge of the done cycle.
    task automatic wait_done(input string tag, input logic exp_dbz, input bit disturb,
                             input logic [31:0] old_hi, input logic [31:0] old_lo);
        int n = 1;
        int busy_cnt = 0;
        check({tag, "_hold_hi"}, 64'(hi), 64'(old_hi));
        check({tag, "_hold_lo"}, 64'(lo), 64'(old_lo));
        while (n <= 80 && !done) begin
            if (busy) busy_cnt++;
            if (disturb && n == 5) begin
                start = 1'b1;
                op = ~op;
                A = $urandom;
                B = $urandom;
                mthi = 1'b1;
                mtlo = 1'b1;
                wdata = $urandom;
            end else if (disturb && n == 6) begin
                start = 1'b0;
                mthi = 1'b0;
                mtlo = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 64'(n), exp_dbz ? 64'd1 : 64'd34);
        check({tag, "_busy_cycles"}, 64'(busy_cnt), exp_dbz ? 64'd0 : 64'd33);
        check({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
        check({tag, "_hi"}, 64'(hi), 64'(m_hi));
        check({tag, "_lo"}, 64'(lo), 64'(m_lo));
    endtask

    task automatic do_op(input string tag, input logic o, input logic u,
                         input logic [31:0] a, input logic [31:0] b, input bit disturb);
        logic [31:0] oh, ol;
        logic dbz;
        oh = m_hi;
        ol = m_lo;
        model_op(o, u, a, b, dbz);
        launch(o, u, a, b);
        wait_done(tag, dbz, disturb, oh, ol);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] oh, ol, x;
        logic dbz;
        int done_seen;

        repeat (3) @(negedge clk);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_dbz", 64'(div_by_zero), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("smul", 1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, 1'b0);
        check("smul_const_hi", 64'(hi), 64'hFFFFFFFF);
        check("smul_const_lo", 64'(lo), 64'hFFFFFFEB);
        do_op("umul", 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("umul_const_hi", 64'(hi), 64'hFFFFFFFE);
        check("umul_const_lo", 64'(lo), 64'h00000001);
        do_op("sdiv", 1'b1, 1'b0, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("sdiv_const_lo", 64'(lo), 64'hFFFFFFFD);
        check("sdiv_const_hi", 64'(hi), 64'hFFFFFFFF);
        do_op("udiv", 1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
        check("udiv_const_lo", 64'(lo), 64'd14);
        check("udiv_const_hi", 64'(hi), 64'd2);
        do_op("sovf", 1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("sovf_const_lo", 64'(lo), 64'h80000000);
        check("sovf_const_hi", 64'(hi), 64'd0);

        mthi = 1'b1; wdata = 32'h1234;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5678;
        @(negedge clk);
        mtlo = 1'b0;
        m_hi = 32'h1234; m_lo = 32'h5678;
        check("mthi", 64'(hi), 64'h1234);
        check("mtlo", 64'(lo), 64'h5678);
        do_op("dbz", 1'b1, 1'b0, 32'hABCD, 32'd0, 1'b0);
        check("dbz_const_hi", 64'(hi), 64'h1234);
        check("dbz_const_lo", 64'(lo), 64'h5678);

        x = $urandom;
        mthi = 1'b1; mtlo = 1'b1; wdata = x;
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        m_hi = x; m_lo = x;
        check("mt_both_hi", 64'(hi), 64'(x));
        check("mt_both_lo", 64'(lo), 64'(x));

        do_op("hs_ignore", 1'b0, 1'b0, $urandom, $urandom, 1'b1);

        x = $urandom;
        m_hi = x;
        oh = m_hi; ol = m_lo;
        model_op(1'b1, 1'b1, 32'd1000, 32'd33, dbz);
        mthi = 1'b1; wdata = x;
        launch(1'b1, 1'b1, 32'd1000, 32'd33);
        mthi = 1'b0;
        wait_done("mt_start", dbz, 1'b0, oh, ol);
        @(negedge clk);

        oh = m_hi; ol = m_lo;
        model_op(1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF, dbz);
        launch(1'b0, 1'b0, 32'h80000000, 32'h7FFFFFFF);
        wait_done("b2b_first", dbz, 1'b0, oh, ol);
        oh = m_hi; ol = m_lo;
        model_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFD, dbz);
        launch(1'b1, 1'b0, 32'h7FFFFFFF, 32'hFFFFFFFD);
        wait_done("b2b_second", dbz, 1'b0, oh, ol);
        @(negedge clk);

        launch(1'b0, 1'b1, $urandom, $urandom);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_hi", 64'(hi), 64'd0);
        check("rstmid_lo", 64'(lo), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("rstmid_no_done", 64'(done_seen), 64'd0);
        do_op("after_rst", 1'b0, 1'b0, 32'hFFFF0001, 32'h00012345, 1'b0);

        for (int i = 0; i < 14; i++) begin
            logic ro, ru;
            logic [31:0] ra, rb;
            ro = 1'($urandom_range(0, 1));
            ru = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d", i), ro, ru, ra, rb, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
